// File: rtl/seven_seg_mux.sv
// Two-digit time-multiplexed driver for a common-anode seven-segment display.
// Both digits and enables are snapshotted once per frame; each slot opens with a dark blanking window.
module seven_seg_mux #(
   parameter int unsigned DIV   = 12000,
   parameter int unsigned BLANK = 240
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] s0,
   input  logic [3:0] s1,
   input  logic [1:0] en,
   output logic [3:0] s,
   output logic [1:0] an,
   output logic       frame
);

   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic          slot, slot_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [3:0]    d0, d0_nx;
   logic [3:0]    d1, d1_nx;
   logic [1:0]    e, e_nx;
   logic          slot_end;
   logic          capture;
   logic          blank_nx;
   logic [3:0]    s_nx;
   logic [1:0]    an_nx;
   logic          frame_nx;

   // Slot sequencing and end-of-frame snapshot of the inputs
   always_comb begin
      slot_end = (cnt == CNT_LAST);
      capture  = slot & slot_end;
      cnt_nx   = slot_end ? '0 : cnt + CW'(1);
      slot_nx  = slot ^ slot_end;
      d0_nx    = capture ? s0 : d0;
      d1_nx    = capture ? s1 : d1;
      e_nx     = capture ? en : e;
   end

   // With no blanking the compare against zero would be constant, so drop it
   if (BLANK == 0) begin : g_noblank
      assign blank_nx = 1'b0;
   end else begin : g_blank
      assign blank_nx = (cnt_nx < CW'(BLANK));
   end

   // Outputs are computed from next state so the registers line up with slot/cnt
   always_comb begin
      s_nx     = slot_nx ? d1_nx : d0_nx;
      an_nx    = 2'b11;
      if (!blank_nx) begin
         an_nx[slot_nx] = ~e_nx[slot_nx];
      end
      frame_nx = slot_nx & (cnt_nx == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         slot  <= 1'b0;
         cnt   <= '0;
         d0    <= 4'h0;
         d1    <= 4'h0;
         e     <= 2'b00;
         s     <= 4'h0;
         an    <= 2'b11;
         frame <= 1'b0;
      end else begin
         slot  <= slot_nx;
         cnt   <= cnt_nx;
         d0    <= d0_nx;
         d1    <= d1_nx;
         e     <= e_nx;
         s     <= s_nx;
         an    <= an_nx;
         frame <= frame_nx;
      end
   end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: directed frame tables plus randomized inputs against a cycle-index model.
module tb_seven_seg_mux;

   typedef struct packed {
      logic [3:0] s;
      logic [1:0] an;
      logic       fr;
   } out_t;

   typedef struct {
      int   dut;
      int   lo;
      int   hi;
      out_t exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] s0 = 4'h0;
   logic [3:0] s1 = 4'h0;
   logic [1:0] en = 2'b00;
   logic [3:0] s_a, s_b;
   logic [1:0] an_a, an_b;
   logic       frame_a, frame_b;

   seven_seg_mux #(.DIV(8), .BLANK(2)) u_a (
      .clk(clk), .reset_n(reset_n), .s0(s0), .s1(s1), .en(en),
      .s(s_a), .an(an_a), .frame(frame_a)
   );

   seven_seg_mux #(.DIV(4), .BLANK(0)) u_b (
      .clk(clk), .reset_n(reset_n), .s0(s0), .s1(s1), .en(en),
      .s(s_b), .an(an_b), .frame(frame_b)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         passed = 0;
   bit         checking = 1'b0;
   int         div_k[2] = '{8, 4};
   int         blank_k[2] = '{2, 0};
   int         t_k[2] = '{0, 0};
   logic [3:0] md0[2];
   logic [3:0] md1[2];
   logic [1:0] me[2];
   out_t       got[2];
   int         tcur;
   vec_t       tbl[$];

   // Expected outputs from the cycle index since reset and the latched frame values
   function automatic out_t model_out(int div, int blank, int t,
                                      logic [3:0] d0, logic [3:0] d1, logic [1:0] e);
      out_t o;
      int   cnt;
      int   slot;
      cnt   = t % div;
      slot  = (t / div) % 2;
      o.s   = (slot == 1) ? d1 : d0;
      o.an  = 2'b11;
      if (cnt >= blank) o.an[slot] = ~e[slot];
      o.fr  = ((t % (2 * div)) == (2 * div - 1));
      return o;
   endfunction

   function automatic vec_t mk(int dut, int lo, int hi, logic [3:0] sv, logic [1:0] av, logic fv);
      vec_t v;
      v.dut = dut;
      v.lo  = lo;
      v.hi  = hi;
      v.exp = '{s: sv, an: av, fr: fv};
      return v;
   endfunction

   task automatic chk(string name, int t, out_t g, out_t x);
      checks++;
      if (g === x) passed++;
      else $display("FAIL %s t=%0d got s=%h an=%b frame=%b expected s=%h an=%b frame=%b",
                    name, t, g.s, g.an, g.fr, x.s, x.an, x.fr);
   endtask

   // One clock: sample mid-cycle, compare against model, advance model, step past the edge
   task automatic cycle(input logic rst_v);
      reset_n = rst_v;
      @(negedge clk);
      got[0] = '{s: s_a, an: an_a, fr: frame_a};
      got[1] = '{s: s_b, an: an_b, fr: frame_b};
      tcur   = t_k[0];
      for (int k = 0; k < 2; k++) begin
         if (checking)
            chk(k == 0 ? "model_a" : "model_b", t_k[k], got[k],
                model_out(div_k[k], blank_k[k], t_k[k], md0[k], md1[k], me[k]));
         if (!rst_v) begin
            t_k[k] = 0;
            md0[k] = 4'h0;
            md1[k] = 4'h0;
            me[k]  = 2'b00;
         end else begin
            if ((t_k[k] % (2 * div_k[k])) == (2 * div_k[k] - 1)) begin
               md0[k] = s0;
               md1[k] = s1;
               me[k]  = en;
            end
            t_k[k]++;
         end
      end
      @(posedge clk);
      #1;
      checking = 1'b1;
   endtask

   initial begin
      tbl.push_back(mk(0,  0, 14, 4'h0, 2'b11, 1'b0));
      tbl.push_back(mk(0, 15, 15, 4'h0, 2'b11, 1'b1));
      tbl.push_back(mk(0, 16, 17, 4'h3, 2'b11, 1'b0));
      tbl.push_back(mk(0, 18, 23, 4'h3, 2'b10, 1'b0));
      tbl.push_back(mk(0, 24, 25, 4'hA, 2'b11, 1'b0));
      tbl.push_back(mk(0, 26, 30, 4'hA, 2'b01, 1'b0));
      tbl.push_back(mk(0, 31, 31, 4'hA, 2'b01, 1'b1));
      tbl.push_back(mk(0, 32, 33, 4'h7, 2'b11, 1'b0));
      tbl.push_back(mk(0, 34, 39, 4'h7, 2'b10, 1'b0));
      tbl.push_back(mk(0, 40, 41, 4'hA, 2'b11, 1'b0));
      tbl.push_back(mk(0, 42, 46, 4'hA, 2'b01, 1'b0));
      tbl.push_back(mk(0, 47, 47, 4'hA, 2'b01, 1'b1));
      tbl.push_back(mk(1,  0,  6, 4'h0, 2'b11, 1'b0));
      tbl.push_back(mk(1,  7,  7, 4'h0, 2'b11, 1'b1));
      tbl.push_back(mk(1,  8, 11, 4'h3, 2'b10, 1'b0));
      tbl.push_back(mk(1, 12, 14, 4'hA, 2'b01, 1'b0));
      tbl.push_back(mk(1, 15, 15, 4'hA, 2'b01, 1'b1));
      tbl.push_back(mk(1, 24, 27, 4'h7, 2'b10, 1'b0));

      // Reset and dark frame, steady mux, tear-free capture of s0 changed mid-frame
      s0 = 4'h3; s1 = 4'hA; en = 2'b11;
      cycle(1'b0);
      cycle(1'b0);
      for (int n = 0; n < 48; n++) begin
         if (t_k[0] == 20) s0 = 4'h7;
         cycle(1'b1);
         foreach (tbl[i])
            if (tcur >= tbl[i].lo && tcur <= tbl[i].hi)
               chk(tbl[i].dut == 0 ? "table_a" : "table_b", tcur, got[tbl[i].dut], tbl[i].exp);
      end

      // Digit 1 disabled: its slots stay dark while s still shows d1
      s0 = 4'h5; s1 = 4'hC; en = 2'b01;
      for (int n = 0; n < 32; n++) begin
         cycle(1'b1);
         if (tcur >= 66 && tcur <= 71) chk("en_digit0", tcur, got[0], '{s: 4'h5, an: 2'b10, fr: 1'b0});
         if (tcur >= 72 && tcur <= 78) chk("en_digit1", tcur, got[0], '{s: 4'hC, an: 2'b11, fr: 1'b0});
      end

      // Mid-slot reset at slot 1, cnt 5, then the dark frame restarts
      while (t_k[0] != 93) cycle(1'b1);
      cycle(1'b0);
      cycle(1'b1);
      chk("rst_mid_a", tcur, got[0], '{s: 4'h0, an: 2'b11, fr: 1'b0});
      chk("rst_mid_b", tcur, got[1], '{s: 4'h0, an: 2'b11, fr: 1'b0});
      for (int n = 0; n < 15; n++) begin
         cycle(1'b1);
         if (tcur == 15) chk("rst_frame", tcur, got[0], '{s: 4'h0, an: 2'b11, fr: 1'b1});
      end

      // Randomized inputs with occasional resets, checked by the model only
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(9, 0) < 3) begin
            s0 = 4'($urandom);
            s1 = 4'($urandom);
            en = 2'($urandom);
         end
         cycle(($urandom_range(149, 0) == 0) ? 1'b0 : 1'b1);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Time-multiplexing driver for the dual common-anode seven-segment display. Alternates between two 4-bit hex digits, drives the selected digit onto the 4-bit input of the downstream hex-to-segment decoder, and drives the active-low anode enables for the two digit transistors. Inserts a dark blanking interval at each digit switch to suppress ghosting. Snapshots both digits once per frame so a displayed frame never mixes old and new values.

## Interface
- DIV, 12000: clock cycles per digit slot (500 µs at 24 MHz); legal range DIV ≥ 2
- BLANK, 240: cycles at the start of each slot with both anodes off; legal range 0 ≤ BLANK < DIV
- clk  input  1  system clock
- reset_n  input  1  synchronous, active-low reset
- s0  input  4  hex digit for display 0 (right)
- s1  input  4  hex digit for display 1 (left)
- en  input  2  per-digit enable; en[k]=0 keeps digit k dark
- s  output  4  digit code to the segment decoder
- an  output  2  anode enables, active-low; an[k]=0 lights digit k
- frame  output  1  one-cycle pulse when new s0/s1/en are captured

## Operation
- State: slot (1 bit, 0 or 1), slot counter cnt (width $clog2(DIV), counts 0..DIV-1), latches d0, d1 (4 b each), e (2 b).
- Slot sequence: slot 0 → slot 1 → slot 0 …; each slot lasts exactly DIV cycles; frame = 2·DIV cycles.
- cnt increments each cycle; at cnt==DIV-1 it wraps to 0 and slot toggles.
- Capture: in the cycle where slot==1 and cnt==DIV-1, load d0←s0, d1←s1, e←en; the new values drive outputs from the next cycle (first cycle of slot 0). frame=1 in that same capture cycle only.
- Input changes at any other time have no effect on outputs until the next capture.
- s = d0 when slot==0, d1 when slot==1, for the entire slot, including blanking, so the decoder settles before the anode turns on.
- an: both 1 while cnt < BLANK. When cnt ≥ BLANK, an[slot] = ~e[slot] and the other bit = 1. At most one anode bit is 0 in any cycle.
- BLANK=0: no blanking; the anode switches directly between digits on the slot boundary.
- Reset (reset_n=0 sampled on a clk edge, at any point, including mid-slot or mid-blank): slot←0, cnt←0, d0←0, d1←0, e←2'b00. Outputs go to s=4'h0, an=2'b11, frame=0. Consequently the first frame after reset is dark; inputs are captured at the end of that frame.

## Timing
- s, an, frame are registered outputs, with no combinational path from inputs to outputs. The value in each cycle is a function of that cycle's slot, cnt, and latches. The implementation computes it from next-state values.
- Cycle 0 is the first rising edge with reset_n=1: slot 0, cnt=0.
- Slot k spans cycles [k·DIV, (k+1)·DIV) within a frame. Anode on-window: cnt = BLANK..DIV-1, which is DIV-BLANK cycles per slot.
- Input-to-display latency is at most 2·DIV+1 cycles. An input change is visible at the first slot-0 cycle after the next capture.
- Duty per digit = (DIV-BLANK)/(2·DIV).

## Test plan
- Reset/dark frame (DIV=8, BLANK=2, s0=4'h3, s1=4'hA, en=2'b11): after reset release, cycles 0–15 → an=2'b11, s=0 in slot 0 and 0 in slot 1. frame=1 at cycle 15 only.
- Steady mux (same setup, second frame, cycles 16–31): cycles 16–17 → an=11, s=3. Cycles 18–23 → an=2'b10, s=3. Cycles 24–25 → an=11, s=A. Cycles 26–31 → an=2'b01, s=A.
- Tear-free capture: change s0 to 4'h7 at cycle 20. Cycles 20–31 still show 3 for digit 0. The new value appears at cycle 32 with s=7, and an=10 from cycle 34.
- Digit enable: en=2'b01 captured → digit 1 slots keep an=11 throughout, while s still cycles to d1. Digit 0 is unaffected.
- BLANK=0 (DIV=4): an alternates 10,10,10,10,01,01,01,01 with no all-off cycle, and never 00.
- Mid-slot reset: assert reset_n=0 for 1 cycle at cnt=5 of slot 1. Next cycle → slot 0, cnt 0, an=11, s=0, latches cleared, and no frame pulse. The sequence then restarts as in the reset/dark-frame scenario.
